// File: rtl/vga_rect_fill_if.sv
// Command channel of the rectangle-fill engine: one rectangle per
// valid/ready handshake. The master (command source) drives the corners
// and the colour. The slave (vga_rect_fill) returns cmd_ready_o.
interface vga_rect_fill_if #(
  parameter int COORD_W = 11,
  parameter int COLOR_W = 2
);
  logic               cmd_valid_i;
  logic               cmd_ready_o;
  logic [COORD_W-1:0] cmd_x0_i;
  logic [COORD_W-1:0] cmd_x1_i;
  logic [COORD_W-1:0] cmd_y0_i;
  logic [COORD_W-1:0] cmd_y1_i;
  logic [COLOR_W-1:0] cmd_color_i;

  modport master (
    output cmd_valid_i, cmd_x0_i, cmd_x1_i, cmd_y0_i, cmd_y1_i, cmd_color_i,
    input  cmd_ready_o
  );

  modport slave (
    input  cmd_valid_i, cmd_x0_i, cmd_x1_i, cmd_y0_i, cmd_y1_i, cmd_color_i,
    output cmd_ready_o
  );
endinterface

// File: rtl/vga_rect_fill.sv
// vga_rect_fill: rectangle-fill drawing engine feeding the frame-buffer
// write port. It latches one command, sorts the corners and emits one pixel
// write per clock in raster order. It then pulses done_o for one cycle.
// Optional feature macro VGA_RECT_FILL_CLIP_EN clips the rectangle to the
// visible HD x VD area. When clipping leaves nothing visible, the command
// completes without any writes.
module vga_rect_fill #(
  parameter int COORD_W = 11,
  parameter int COLOR_W = 2,
  parameter int HD      = 800,
  parameter int VD      = 600
) (
  input  logic               clk_i,
  input  logic               arstn_i,
  vga_rect_fill_if.slave     cmd,
  input  logic               abort_i,
  output logic               we_o,
  output logic [COORD_W-1:0] addr_x_o,
  output logic [COORD_W-1:0] addr_y_o,
  output logic [COLOR_W-1:0] color_o,
  output logic               busy_o,
  output logic               done_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } state_t;

  // The visible area must be addressable, otherwise clipping limits are meaningless.
  if (HD < 1 || HD > (1 << COORD_W) || VD < 1 || VD > (1 << COORD_W)) begin : g_bad_area
    $error("vga_rect_fill: HD/VD outside the COORD_W address range");
  end

  function automatic logic [COORD_W-1:0] umin(input logic [COORD_W-1:0] a,
                                              input logic [COORD_W-1:0] b);
    return (a < b) ? a : b;
  endfunction

  function automatic logic [COORD_W-1:0] umax(input logic [COORD_W-1:0] a,
                                              input logic [COORD_W-1:0] b);
    return (a < b) ? b : a;
  endfunction

  state_t             r_state;
  state_t             w_state_nxt;
  logic               r_we;
  logic               r_done;
  logic [COORD_W-1:0] r_cur_x;
  logic [COORD_W-1:0] r_cur_y;
  logic [COLOR_W-1:0] r_color;
  logic [COORD_W-1:0] r_xmin;
  logic [COORD_W-1:0] r_xmax;
  logic [COORD_W-1:0] r_ymax;

  logic               w_we_nxt;
  logic               w_done_nxt;
  logic [COORD_W-1:0] w_x_nxt;
  logic [COORD_W-1:0] w_y_nxt;
  logic               w_load;
  logic               w_empty;
  logic               w_last;

  logic [COORD_W-1:0] w_xmin;
  logic [COORD_W-1:0] w_ymin;
  logic [COORD_W-1:0] w_xmax_s;
  logic [COORD_W-1:0] w_ymax_s;
  logic [COORD_W-1:0] w_xmax;
  logic [COORD_W-1:0] w_ymax;

  // Corner sorting with unsigned compares on the incoming command
  assign w_xmin   = umin(cmd.cmd_x0_i, cmd.cmd_x1_i);
  assign w_xmax_s = umax(cmd.cmd_x0_i, cmd.cmd_x1_i);
  assign w_ymin   = umin(cmd.cmd_y0_i, cmd.cmd_y1_i);
  assign w_ymax_s = umax(cmd.cmd_y0_i, cmd.cmd_y1_i);

`ifdef VGA_RECT_FILL_CLIP_EN
  localparam logic [COORD_W-1:0] XLAST = COORD_W'(HD - 1);
  localparam logic [COORD_W-1:0] YLAST = COORD_W'(VD - 1);

  function automatic logic [COORD_W-1:0] clamp(input logic [COORD_W-1:0] v,
                                               input logic [COORD_W-1:0] lim);
    return (v > lim) ? lim : v;
  endfunction

  assign w_xmax  = clamp(w_xmax_s, XLAST);
  assign w_ymax  = clamp(w_ymax_s, YLAST);
  assign w_empty = (w_xmin > XLAST) || (w_ymin > YLAST);
`else
  assign w_xmax  = w_xmax_s;
  assign w_ymax  = w_ymax_s;
  assign w_empty = 1'b0;
`endif

  // The end test is an equality compare, so a bound of all-ones never needs the counter to wrap
  assign w_last = (r_cur_x == r_xmax) && (r_cur_y == r_ymax);

  // Next-state and next-output decode; every registered output is computed here
  always_comb begin
    w_state_nxt = r_state;
    w_we_nxt    = 1'b0;
    w_done_nxt  = 1'b0;
    w_x_nxt     = r_cur_x;
    w_y_nxt     = r_cur_y;
    w_load      = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (cmd.cmd_valid_i) begin
          w_load = 1'b1;
          if (w_empty) begin
            w_state_nxt = DONE;
            w_done_nxt  = 1'b1;
          end else begin
            w_state_nxt = FILL;
            w_we_nxt    = 1'b1;
            w_x_nxt     = w_xmin;
            w_y_nxt     = w_ymin;
          end
        end
      end
      FILL: begin
        if (abort_i || w_last) begin
          w_state_nxt = DONE;
          w_done_nxt  = 1'b1;
        end else begin
          w_we_nxt = 1'b1;
          if (r_cur_x == r_xmax) begin
            w_x_nxt = r_xmin;
            w_y_nxt = r_cur_y + COORD_W'(1);
          end else begin
            w_x_nxt = r_cur_x + COORD_W'(1);
          end
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // State register and registered pixel-port outputs, cleared asynchronously
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      r_state <= IDLE;
      r_we    <= 1'b0;
      r_done  <= 1'b0;
      r_cur_x <= '0;
      r_cur_y <= '0;
      r_color <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_we    <= w_we_nxt;
      r_done  <= w_done_nxt;
      r_cur_x <= w_x_nxt;
      r_cur_y <= w_y_nxt;
      if (w_load) begin
        r_color <= cmd.cmd_color_i;
      end
    end
  end

  // Rectangle bounds captured at the handshake; only read while filling, so no reset
  always_ff @(posedge clk_i) begin
    if (w_load) begin
      r_xmin <= w_xmin;
      r_xmax <= w_xmax;
      r_ymax <= w_ymax;
    end
  end

  assign cmd.cmd_ready_o = (r_state == IDLE);
  assign busy_o          = (r_state != IDLE);
  assign we_o            = r_we;
  assign done_o          = r_done;
  assign addr_x_o        = r_cur_x;
  assign addr_y_o        = r_cur_y;
  assign color_o         = r_color;

endmodule

// File: tb/tb_vga_rect_fill.sv
// Directed bench for vga_rect_fill. A pixel scoreboard is filled at each
// handshake and drained by a write monitor. Per-cycle checks cover
// we/done/ready timing.
module tb_vga_rect_fill;
  localparam int COORD_W = 11;
  localparam int COLOR_W = 2;
  localparam int HD      = 800;
  localparam int VD      = 600;
  localparam int BUDGET  = 1000;

  logic               clk   = 1'b0;
  logic               arstn = 1'b0;
  logic               abort = 1'b0;
  logic               we, busy, done;
  logic [COORD_W-1:0] ax, ay;
  logic [COLOR_W-1:0] col;

  vga_rect_fill_if #(.COORD_W(COORD_W), .COLOR_W(COLOR_W)) cmd_if ();

  vga_rect_fill #(.COORD_W(COORD_W), .COLOR_W(COLOR_W), .HD(HD), .VD(VD)) dut (
    .clk_i    (clk),
    .arstn_i  (arstn),
    .cmd      (cmd_if.slave),
    .abort_i  (abort),
    .we_o     (we),
    .addr_x_o (ax),
    .addr_y_o (ay),
    .color_o  (col),
    .busy_o   (busy),
    .done_o   (done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic [COLOR_W-1:0] c;
  } pix_t;

  pix_t exp_q[$];
  pix_t mon_e;
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Write monitor: every write must match the head of the scoreboard
  always @(negedge clk) begin
    if (arstn && we) begin
      check("sb_pending", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        check("pixel", {ax, ay, col}, mon_e);
      end
    end
  end

  // Drive a command right after a negedge, wait for ready, handshake, push expectations
  task automatic hs(input int x0, input int y0, input int x1, input int y1, input int c,
                    input int limit, output int nexp, output int waited);
    int  xmn, xmx, ymn, ymx, n;
    bit  empty;
    cmd_if.cmd_valid_i = 1'b1;
    cmd_if.cmd_x0_i    = COORD_W'(x0);
    cmd_if.cmd_y0_i    = COORD_W'(y0);
    cmd_if.cmd_x1_i    = COORD_W'(x1);
    cmd_if.cmd_y1_i    = COORD_W'(y1);
    cmd_if.cmd_color_i = COLOR_W'(c);
    waited = 0;
    while (!cmd_if.cmd_ready_o && waited < BUDGET) begin
      @(negedge clk);
      waited++;
    end
    check("ready_wait", cmd_if.cmd_ready_o, 1);
    @(posedge clk);
    xmn = (x0 < x1) ? x0 : x1;
    xmx = (x0 < x1) ? x1 : x0;
    ymn = (y0 < y1) ? y0 : y1;
    ymx = (y0 < y1) ? y1 : y0;
    empty = 1'b0;
`ifdef VGA_RECT_FILL_CLIP_EN
    if (xmx > HD - 1) xmx = HD - 1;
    if (ymx > VD - 1) ymx = VD - 1;
    empty = (xmn > HD - 1) || (ymn > VD - 1);
`endif
    n = 0;
    if (!empty) begin
      for (int y = ymn; y <= ymx; y++) begin
        for (int x = xmn; x <= xmx; x++) begin
          if (n < limit) begin
            exp_q.push_back({COORD_W'(x), COORD_W'(y), COLOR_W'(c)});
            n++;
          end
        end
      end
    end
    nexp = n;
    #1;
    cmd_if.cmd_valid_i = 1'b0;
    cmd_if.cmd_x0_i    = COORD_W'($urandom);
    cmd_if.cmd_y0_i    = COORD_W'($urandom);
    cmd_if.cmd_x1_i    = COORD_W'($urandom);
    cmd_if.cmd_y1_i    = COORD_W'($urandom);
    cmd_if.cmd_color_i = COLOR_W'($urandom);
  endtask

  // Cycle-by-cycle checks of one command after its handshake edge
  task automatic check_run(input int nwr, input int abort_k);
    for (int k = 1; k <= nwr + 1; k++) begin
      @(negedge clk);
      if (k == abort_k + 1) abort = 1'b0;
      check($sformatf("we_k%0d", k), we, 32'(k <= nwr));
      check($sformatf("done_k%0d", k), done, 32'(k == nwr + 1));
      check($sformatf("ready_busy_k%0d", k), {cmd_if.cmd_ready_o, busy}, 32'b01);
      if (k == abort_k) abort = 1'b1;
    end
    @(negedge clk);
    check("idle_ready_busy_done", {cmd_if.cmd_ready_o, busy, done, we}, 32'b1000);
    check("sb_drained", exp_q.size(), 0);
  endtask

  initial begin
    int nexp, waited;
    cmd_if.cmd_valid_i = 1'b0;
    cmd_if.cmd_x0_i    = '0;
    cmd_if.cmd_y0_i    = '0;
    cmd_if.cmd_x1_i    = '0;
    cmd_if.cmd_y1_i    = '0;
    cmd_if.cmd_color_i = '0;

    // Reset state; a valid held during reset must not be accepted
    cmd_if.cmd_valid_i = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_outputs", {we, done, busy, cmd_if.cmd_ready_o}, 32'b0001);
    check("rst_addr_color", {ax, ay, col}, 0);
    cmd_if.cmd_valid_i = 1'b0;
    #2 arstn = 1'b1;
    @(negedge clk);
    check("post_rst_idle", {we, busy, done}, 0);

    // Normal fill 3x2
    hs(10, 20, 12, 21, 2, 1 << 30, nexp, waited);
    check("normal_nexp", nexp, 6);
    check_run(nexp, 0);

    // Swapped corners, single row
    hs(5, 7, 3, 7, 1, 1 << 30, nexp, waited);
    check("swap_nexp", nexp, 3);
    check_run(nexp, 0);

    // Single pixel followed by a command held valid
    hs(0, 0, 0, 0, 3, 1 << 30, nexp, waited);
    cmd_if.cmd_valid_i = 1'b1;
    cmd_if.cmd_x0_i    = COORD_W'(21);
    cmd_if.cmd_y0_i    = COORD_W'(30);
    cmd_if.cmd_x1_i    = COORD_W'(20);
    cmd_if.cmd_y1_i    = COORD_W'(30);
    cmd_if.cmd_color_i = COLOR_W'(2);
    check_run(nexp, 0);
    hs(21, 30, 20, 30, 2, 1 << 30, nexp, waited);
    check("b2b_no_wait", waited, 0);
    check_run(nexp, 0);

    // Abort in the 7th write cycle of a 100x100 fill
    hs(0, 0, 99, 99, 1, 7, nexp, waited);
    check_run(7, 7);

`ifdef VGA_RECT_FILL_CLIP_EN
    // Partially visible rectangle is clamped to the last visible column/row
    hs(798, 599, 900, 700, 1, 1 << 30, nexp, waited);
    check("clip_nexp", nexp, 2);
    check_run(nexp, 0);
    // Fully off-screen: no writes, done right after the handshake
    hs(850, 0, 860, 0, 1, 1 << 30, nexp, waited);
    check("clip_empty_nexp", nexp, 0);
    check_run(nexp, 0);
`else
    // Corners at the top of the coordinate range must still terminate
    hs(2047, 2046, 2046, 2047, 3, 1 << 30, nexp, waited);
    check("max_nexp", nexp, 4);
    check_run(nexp, 0);
`endif

    // Reset asserted mid-fill
    hs(100, 100, 119, 119, 1, 1 << 30, nexp, waited);
    repeat (5) @(negedge clk);
    #2 arstn = 1'b0;
    #1;
    check("midrst_async", {we, busy, done, cmd_if.cmd_ready_o}, 32'b0001);
    exp_q.delete();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("midrst_quiet_%0d", k), {we, done}, 0);
    end
    #2 arstn = 1'b1;
    @(negedge clk);
    check("midrst_release", {cmd_if.cmd_ready_o, busy, done, we}, 32'b1000);
    hs(4, 5, 5, 4, 3, 1 << 30, nexp, waited);
    check("after_rst_nexp", nexp, 4);
    check_run(nexp, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_rect_fill.md
# vga_rect_fill

Rectangle-fill drawing engine that sits directly upstream of `vga_top`'s frame-buffer write port. It accepts one rectangle command at a time over a valid/ready handshake, sorts the corner coordinates, and emits one pixel write per clock in raster order. Its `we_o`, `addr_x_o`, `addr_y_o` and `color_o` outputs drive `we_i`, `addr_x_i`, `addr_y_i` and `color_i` of the frame buffer.

## Interface
Parameters:
- `COORD_W`, 11, width of every coordinate; matches the frame-buffer address width.
- `COLOR_W`, 2, colour code width (BLACK=0, WHITE=1, BLUE=2, GREEN=3).
- `HD`, 800, visible width in pixels; used only for clipping.
- `VD`, 600, visible height in pixels; used only for clipping.

Ports:
- `clk_i`  in  1  sole clock.
- `arstn_i`  in  1  asynchronous, active-low reset.
- `cmd_valid_i`  in  1  command present.
- `cmd_ready_o`  out  1  engine can accept a command; high only in IDLE.
- `cmd_x0_i`, `cmd_x1_i`  in  COORD_W  column corners, in either order.
- `cmd_y0_i`, `cmd_y1_i`  in  COORD_W  row corners, in either order.
- `cmd_color_i`  in  COLOR_W  fill colour.
- `abort_i`  in  1  terminates the current fill.
- `we_o`  out  1  pixel write strobe.
- `addr_x_o`  out  COORD_W  pixel column.
- `addr_y_o`  out  COORD_W  pixel row.
- `color_o`  out  COLOR_W  pixel colour.
- `busy_o`  out  1  high in FILL and DONE.
- `done_o`  out  1  one-cycle pulse when a command completes or is aborted.

## Operation
- The engine has three states: IDLE, FILL and DONE.
- **IDLE**
  - `cmd_ready_o`=1.
  - A handshake (`cmd_valid_i` && `cmd_ready_o` at a rising edge) latches the command.
  - On latch: xmin/xmax = min/max(x0,x1) and ymin/ymax = min/max(y0,y1), computed with unsigned compares; the colour is latched too.
  - Next state is FILL.
- **FILL**
  - Each cycle: `we_o`=1, `addr_x_o`=cur_x, `addr_y_o`=cur_y, `color_o`=latched colour.
  - cur_x starts at xmin and cur_y at ymin.
  - While cur_x<xmax, cur_x increments. When cur_x==xmax, cur_x wraps to xmin and cur_y increments.
  - The write at (xmax,ymax) is the last one; next state is DONE.
  - `abort_i` sampled high in FILL: the write presented in that cycle still completes, and next state is DONE.
- **DONE**
  - `we_o`=0 and `done_o`=1 for exactly one cycle.
  - Next state is IDLE.
- Input command fields are ignored outside the handshake cycle and need not be held.
- A degenerate rectangle (x0==x1 and/or y0==y1) is legal: a single row, column or pixel.
- Counters are COORD_W wide. xmax or ymax = 2^COORD_W−1 must terminate correctly, with no wrap to 0 before the end compare.
- `abort_i` is ignored in IDLE and DONE.

## Timing
- All outputs are registered, except `cmd_ready_o` and `busy_o`, which are decoded from the state register.
- Reset (`arstn_i` low):
  - State is IDLE.
  - `we_o`=0, `done_o`=0, `addr_x_o`=0, `addr_y_o`=0, `color_o`=0, `busy_o`=0, `cmd_ready_o`=1.
  - Handshakes are not recognised while reset is asserted.
- Handshake accepted at edge N. For a W×H rectangle:
  - first `we_o` in cycle N+1;
  - last `we_o` in cycle N+W·H;
  - `done_o` in cycle N+W·H+1;
  - `cmd_ready_o` returns high in cycle N+W·H+2.
- Throughput is one pixel per clock; there is no backpressure from the frame buffer.
- Abort sampled at edge M in FILL: `we_o`=0 and `done_o`=1 in cycle M+1, and IDLE in cycle M+2.
- Reset asserted mid-fill forces IDLE immediately (asynchronous) and drops `we_o`; no `done_o` is generated.

## Configuration
- Macro: `VGA_RECT_FILL_CLIP_EN`.
- **Defined:**
  - After sorting, xmax is clamped to HD−1 and ymax to VD−1.
  - If xmin>HD−1 or ymin>VD−1, the command is empty: FILL is skipped, IDLE goes directly to DONE, and `done_o` is high in cycle N+1 with no writes.
- **Undefined:**
  - Coordinates are used unclamped.
  - Off-screen addresses are emitted as-is; the downstream buffer owns their handling.

## Test plan
- **Normal fill:** reset, then cmd (x0=10,y0=20,x1=12,y1=21,color=2).
  - Expect exactly 6 writes: (10,20),(11,20),(12,20),(10,21),(11,21),(12,21), all with `color_o`=2 and no gaps.
  - Expect `done_o` one cycle after the last write.
- **Swapped corners:** cmd (x0=5,x1=3,y0=7,y1=7,color=1).
  - Expect writes (3,7),(4,7),(5,7) and `cmd_ready_o`=0 throughout until IDLE.
- **Single pixel and back-to-back:** cmd (0,0,0,0,3), then a second cmd held valid.
  - First command: one write at (0,0), `done_o` in the next cycle.
  - Second command accepted in the first cycle `cmd_ready_o`=1; no writes lost or duplicated.
- **Abort:** 100×100 fill, `abort_i` high in the 7th write cycle.
  - Expect 7 writes total, `done_o` in the following cycle, and IDLE after that.
- **Clip, with `VGA_RECT_FILL_CLIP_EN`:**
  - cmd (798,599,900,700,1): expect writes (798,599),(799,599) only.
  - cmd (850,0,860,0,1): expect no writes and `done_o` one cycle after the handshake.
- **Reset mid-fill:** assert `arstn_i` low during FILL.
  - `we_o`=0 immediately and no `done_o`.
  - After release, `cmd_ready_o`=1 and a new command fills correctly.
